intt_bf: RTL

INTT_BF -- requirements
Module: intt_bf

---
 rtl/ntt_pkg.sv | 37 +++
 rtl/mod_mul_q.sv | 47 ++++
 rtl/intt_bf.sv | 108 ++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg -- constants and helpers shared by the forward and inverse NTT
// butterflies for the modulus Q = 2^23 - 2^13 + 1 = 8380417.
//
// Contents:
//   DW           operand / result width (23)
//   PW           full product width (46)
//   Q            modulus
//   BARRETT_K/M  Barrett shift and multiplier, M = floor(2^K / Q)
//   cond_sub_q   one conditional subtraction of Q, maps [0,2Q) -> [0,Q)
//   half_mod_q   x * 2^-1 mod Q for canonical x
package ntt_pkg;

  localparam int DW = 23;
  localparam int PW = 46;
  localparam int MW = 26;
  localparam logic [DW-1:0] Q = 23'd8380417;

  // K = PW + 2 keeps the Barrett quotient estimate within one of the true
  // quotient for every product below 2^46, so the remainder is below 2Q and
  // a single final subtraction is enough.
  localparam int BARRETT_K = 48;
  localparam logic [MW-1:0] BARRETT_M = MW'((64'd1 << BARRETT_K) / 64'(Q));

  // Input must be below 2Q.
  function automatic logic [DW-1:0] cond_sub_q(input logic [DW:0] x);
    if (x >= {1'b0, Q}) return DW'(x - {1'b0, Q});
    else return DW'(x);
  endfunction

  // Even x halves directly; odd x becomes even once Q (odd) is added.
  function automatic logic [DW-1:0] half_mod_q(input logic [DW-1:0] x);
    logic [DW:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, Q}) : {1'b0, x};
    return DW'(t >> 1);
  endfunction

endpackage

// File: rtl/mod_mul_q.sv
// mod_mul_q -- pipelined 23x23 modular multiplier for Q = 8380417.
// Covers two pipeline stages of the butterfly:
//   stage A: full 46-bit product a*b registered
//   stage B: Barrett reduction registered; r is congruent to a*b mod Q and
//            lies in [0, 2Q), the final subtraction is left to the caller's
//            output stage.
// Ports:
//   clk, reset (async, active-low), stall (freeze both stages)
//   a, b  : canonical operands in [0, Q)
//   r     : partially reduced result, 24 bits, 2-cycle latency
module mod_mul_q
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW:0]   r
);

  logic [PW-1:0]    prod_q;
  logic [PW+MW-1:0] pm;
  logic [DW:0]      qest;
  logic [47:0]      qq;
  logic [47:0]      rem;

  // Barrett: qest = floor(p * M / 2^K) is the true quotient or one less,
  // so p - qest*Q is non-negative and below 2Q.
  always_comb begin
    pm   = (PW+MW)'(prod_q) * (PW+MW)'(BARRETT_M);
    qest = (DW+1)'(pm >> BARRETT_K);
    qq   = 48'(qest) * 48'(Q);
    rem  = 48'(prod_q) - qq;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
      r      <= '0;
    end else if (!stall) begin
      prod_q <= PW'(a) * PW'(b);
      r      <= (DW+1)'(rem);
    end
  end

endmodule

// File: rtl/intt_bf.sv
// intt_bf -- Gentleman-Sande inverse NTT butterfly, Q = 8380417.
//   out0 = (a + b) mod Q
//   out1 = ((a - b) mod Q) * phi mod Q
// Four pipeline stages: S1 add/sub, S2 multiply, S3 reduce, S4 correct and
// output register. One operand set per clock; a set presented in cycle n
// shows on out_valid in cycle n+4 when nothing stalls.
//
// Handshake: a set transfers in on any cycle with in_valid=1 and in_ready=1,
// and a result transfers out on any cycle with out_valid=1 and out_ready=1.
// The only back-pressure is a global stall (out_valid=1, out_ready=0) that
// freezes every stage, so in_ready = !stall and a new set may enter in the
// same cycle a result leaves.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid / in_ready, in0 (a), in1 (b), phi (inverse twiddle)
//   out_valid / out_ready, out0, out1
//
// Build option: define INTT_DIV2_EN to multiply both outputs by 2^-1 mod Q
// in S4 (no extra latency); eight layers then give the full 1/256 scaling.
module intt_bf
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] phi,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out0,
  output logic [DW-1:0] out1
);

  logic          stall;
  logic          v1, v2, v3;
  logic [DW-1:0] s1_sum, s1_dif, s1_phi;
  logic [DW-1:0] s2_sum, s3_sum;
  logic [DW:0]   add_w, sub_w;
  logic [DW-1:0] sum_n, dif_n;
  logic [DW:0]   mul_r;
  logic [DW-1:0] res0_n, res1_n;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // S1: 24-bit sum reduced once; a borrow out of the difference adds Q back.
  always_comb begin
    add_w = {1'b0, in0} + {1'b0, in1};
    sub_w = {1'b0, in0} - {1'b0, in1};
    sum_n = cond_sub_q(add_w);
    dif_n = sub_w[DW] ? (sub_w[DW-1:0] + Q) : sub_w[DW-1:0];
  end

  // S2/S3: product and reduction of the difference with phi.
  mod_mul_q u_mul (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .a     (s1_dif),
    .b     (s1_phi),
    .r     (mul_r)
  );

  // S4: final correction of the product, optional halving of both results.
  always_comb begin
`ifdef INTT_DIV2_EN
    res0_n = half_mod_q(s3_sum);
    res1_n = half_mod_q(cond_sub_q(mul_r));
`else
    res0_n = s3_sum;
    res1_n = cond_sub_q(mul_r);
`endif
  end

  // The sum rides through S2/S3 alongside the multiplier so out0 and out1
  // always belong to the same operand set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      s1_sum    <= '0;
      s1_dif    <= '0;
      s1_phi    <= '0;
      s2_sum    <= '0;
      s3_sum    <= '0;
      out0      <= '0;
      out1      <= '0;
    end else if (!stall) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      s1_sum    <= sum_n;
      s1_dif    <= dif_n;
      s1_phi    <= phi;
      s2_sum    <= s1_sum;
      s3_sum    <= s2_sum;
      out0      <= res0_n;
      out1      <= res1_n;
    end
  end

endmodule
